motoro3_gate_driver: RTL and testbench

- Downstream of the motoro3 commutation state machine (six-step sequencer).
- Converts per-phase enable/high-low commands plus the PWM chop signal into six registered gate-drive outputs (high-side and low-side per phase).
- Guarantees dead time on every high/low transition and provides a latched over-current shutdown.
- Outputs drive the external half-bridge driver ICs directly.

---
 rtl/motoro3_gate_driver.sv | 163 ++++++++++++++++
 tb/tb_motoro3_gate_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_gate_driver.sv
// Six-output gate driver for the motoro3 six-step sequencer: per-phase dead-time FSMs plus a
// latched over-current shutdown. Define MOTORO3_GD_SYNC_RECT_EN for synchronous rectification.
module motoro3_gate_driver #(
  parameter int unsigned DEAD_CYC = 20,
  parameter int unsigned DT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm,
  input  logic       aE,
  input  logic       aH1_L0,
  input  logic       bE,
  input  logic       bH1_L0,
  input  logic       cE,
  input  logic       cH1_L0,
  input  logic [3:0] m3step,
  input  logic       ocp,
  input  logic       fault_clr,
  output logic       aHS,
  output logic       aLS,
  output logic       bHS,
  output logic       bLS,
  output logic       cHS,
  output logic       cLS,
  output logic       gd_fault,
  output logic       gd_ready
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDead} phase_st_e;

  localparam logic [DT_W-1:0] DeadLoad = DT_W'(DEAD_CYC - 1);

  phase_st_e       state_q [3];
  phase_st_e       state_d [3];
  logic [DT_W-1:0] cnt_q   [3];
  logic [DT_W-1:0] cnt_d   [3];
  logic [2:0]      hs_q, hs_d;
  logic [2:0]      ls_q, ls_d;
  logic            ocp_meta_q, ocp_sync_q;
  logic            gd_fault_q, gd_fault_d;

  logic [2:0] en, lvl;
  logic [2:0] req_h, req_l;
  logic       step_ok;
  logic       force_dead;

  assign en      = {cE, bE, aE};
  assign lvl     = {cH1_L0, bH1_L0, aH1_L0};
  assign step_ok = (m3step != 4'd0) && (m3step <= 4'd6);
  // Hold every phase in DEAD from the first synchronised ocp until the fault is cleared, so
  // the dead time restarts from the clearing edge.
  assign force_dead = ocp_sync_q | gd_fault_q;

  always_comb begin
    req_h = '0;
    req_l = '0;
    for (int i = 0; i < 3; i++) begin
      if (step_ok && !gd_fault_q) begin
        req_h[i] = en[i] & lvl[i] & pwm;
`ifdef MOTORO3_GD_SYNC_RECT_EN
        req_l[i] = en[i] & (~lvl[i] | ~pwm);
`else
        req_l[i] = en[i] & ~lvl[i];
`endif
      end
    end
  end

  always_comb begin
    gd_fault_d = gd_fault_q;
    if (!gd_fault_q && ocp_sync_q) begin
      gd_fault_d = 1'b1;
    end else if (gd_fault_q && fault_clr && !ocp_sync_q) begin
      gd_fault_d = 1'b0;
    end
  end

  always_comb begin
    hs_d = '0;
    ls_d = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StIdle: begin
          if (req_h[i]) begin
            state_d[i] = StHigh;
          end else if (req_l[i]) begin
            state_d[i] = StLow;
          end
        end
        StHigh: begin
          if (!req_h[i]) begin
            state_d[i] = StDead;
            cnt_d[i]   = DeadLoad;
          end
        end
        StLow: begin
          if (!req_l[i]) begin
            state_d[i] = StDead;
            cnt_d[i]   = DeadLoad;
          end
        end
        StDead: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - DT_W'(1);
          end else if (req_h[i]) begin
            state_d[i] = StHigh;
          end else if (req_l[i]) begin
            state_d[i] = StLow;
          end else begin
            state_d[i] = StIdle;
          end
        end
        default: begin
          state_d[i] = StDead;
          cnt_d[i]   = DeadLoad;
        end
      endcase
      if (force_dead) begin
        state_d[i] = StDead;
        cnt_d[i]   = DeadLoad;
      end
      // Gate outputs are registered copies of the next state, so HS/LS can never overlap.
      hs_d[i] = (state_d[i] == StHigh);
      ls_d[i] = (state_d[i] == StLow);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StDead;
        cnt_q[i]   <= DeadLoad;
      end
      hs_q       <= '0;
      ls_q       <= '0;
      ocp_meta_q <= 1'b0;
      ocp_sync_q <= 1'b0;
      gd_fault_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      hs_q       <= hs_d;
      ls_q       <= ls_d;
      ocp_meta_q <= ocp;
      ocp_sync_q <= ocp_meta_q;
      gd_fault_q <= gd_fault_d;
    end
  end

  assign aHS      = hs_q[0];
  assign aLS      = ls_q[0];
  assign bHS      = hs_q[1];
  assign bLS      = ls_q[1];
  assign cHS      = hs_q[2];
  assign cLS      = ls_q[2];
  assign gd_fault = gd_fault_q;
  assign gd_ready = (state_q[0] != StDead) && (state_q[1] != StDead) && (state_q[2] != StDead);

endmodule

// File: tb/tb_motoro3_gate_driver.sv
// Scoreboard bench for motoro3_gate_driver with DEAD_CYC=4: directed vectors, then random
// stimulus under gate-overlap and dead-time invariant monitors.
module tb_motoro3_gate_driver;

  localparam int unsigned Dead = 4;

  logic       clk = 1'b0;
  logic       rst, pwm, aE, aH1_L0, bE, bH1_L0, cE, cH1_L0, ocp, fault_clr;
  logic [3:0] m3step;
  logic       aHS, aLS, bHS, bLS, cHS, cLS, gd_fault, gd_ready;

  typedef struct {
    string      name;
    logic [7:0] val;
    logic [7:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected vector order: {aHS, aLS, bHS, bLS, cHS, cLS, gd_fault, gd_ready}
  localparam logic [7:0] All = 8'hFF;

  motoro3_gate_driver #(
    .DEAD_CYC(Dead),
    .DT_W    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pwm      (pwm),
    .aE       (aE),
    .aH1_L0   (aH1_L0),
    .bE       (bE),
    .bH1_L0   (bH1_L0),
    .cE       (cE),
    .cH1_L0   (cH1_L0),
    .m3step   (m3step),
    .ocp      (ocp),
    .fault_clr(fault_clr),
    .aHS      (aHS),
    .aLS      (aLS),
    .bHS      (bHS),
    .bLS      (bLS),
    .cHS      (cHS),
    .cLS      (cLS),
    .gd_fault (gd_fault),
    .gd_ready (gd_ready)
  );

  always #50 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input string name, input logic [7:0] val, input logic [7:0] mask);
    exp_t e;
    e.name = name;
    e.val  = val;
    e.mask = mask;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: scoreboard pop plus per-phase invariants.
  logic [7:0] obs;
  logic [2:0] prev_hs = '0;
  logic [2:0] prev_ls = '0;
  int         zero_run [3] = '{0, 0, 0};

  always @(posedge clk) begin
    exp_t e;
    logic hs, ls;
    #1;
    obs = {aHS, aLS, bHS, bLS, cHS, cLS, gd_fault, gd_ready};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.mask != 8'h00) begin
        checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
          errors++;
          $display("FAIL %s: got %b required %b", e.name, obs, e.val);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      hs = obs[7-2*i];
      ls = obs[6-2*i];
      checks++;
      if (hs === 1'b1 && ls === 1'b1) begin
        errors++;
        $display("FAIL overlap phase %0d: got HS=%b LS=%b required not both 1", i, hs, ls);
      end
      if ((hs && !prev_hs[i]) || (ls && !prev_ls[i])) begin
        checks++;
        if (zero_run[i] < Dead) begin
          errors++;
          $display("FAIL deadtime phase %0d: got %0d off cycles required >= %0d",
                   i, zero_run[i], Dead);
        end
      end
      if (!hs && !ls) begin
        if (zero_run[i] < 1000) zero_run[i]++;
      end else begin
        zero_run[i] = 0;
      end
      prev_hs[i] = hs;
      prev_ls[i] = ls;
    end
  end

  initial begin
    rst = 1'b1; pwm = 1'b0; m3step = 4'd0; ocp = 1'b0; fault_clr = 1'b0;
    aE = 1'b0; aH1_L0 = 1'b0; bE = 1'b0; bH1_L0 = 1'b0; cE = 1'b0; cH1_L0 = 1'b0;

    repeat (2) step("reset", 8'b00000000, All);

    rst = 1'b0; m3step = 4'd1; pwm = 1'b1;
    aE = 1'b1; aH1_L0 = 1'b1; cE = 1'b1; cH1_L0 = 1'b0;
    repeat (3) step("rst_release_dead", 8'b00000000, All);
    step("step1_on", 8'b10000101, All);
    step("step1_hold", 8'b10000101, All);

    m3step = 4'd6; cH1_L0 = 1'b1;
    repeat (4) step("step6_c_dead", 8'b10000000, All);
    step("step6_c_high", 8'b10001001, All);

    pwm = 1'b0;
    step("chop_off", 8'b00000000, All);
    pwm = 1'b1;
    repeat (3) step("chop_stretch", 8'b00000000, All);
    step("chop_resume", 8'b10001001, All);

    pwm = 1'b0;
    repeat (4) step("long_chop_dead", 8'b00000000, All);
`ifdef MOTORO3_GD_SYNC_RECT_EN
    repeat (2) step("long_chop_rect", 8'b01000101, All);
    pwm = 1'b1;
    repeat (4) step("rect_swap_dead", 8'b00000000, All);
`else
    repeat (2) step("long_chop_idle", 8'b00000001, All);
    pwm = 1'b1;
`endif
    step("long_chop_resume", 8'b10001001, All);

    m3step = 4'd0;
    repeat (4) step("invalid_dead", 8'b00000000, All);
    step("invalid_idle", 8'b00000001, All);
    m3step = 4'd7;
    repeat (2) step("step7_idle", 8'b00000001, All);

    m3step = 4'd2; aE = 1'b1; aH1_L0 = 1'b1; bE = 1'b1; bH1_L0 = 1'b0;
    cE = 1'b0; cH1_L0 = 1'b0;
    step("step2_on", 8'b10010001, All);

    ocp = 1'b1;
    step("ocp_sync1", 8'b10010001, All);
    ocp = 1'b0;
    step("ocp_sync2", 8'b10010001, All);
    step("ocp_fault", 8'b00000010, All);
    repeat (3) step("fault_hold", 8'b00000010, All);
    ocp = 1'b1;
    repeat (2) step("ocp_again", 8'b00000010, All);
    fault_clr = 1'b1;
    step("clr_blocked", 8'b00000010, All);
    fault_clr = 1'b0; ocp = 1'b0;
    repeat (2) step("ocp_release", 8'b00000010, All);
    fault_clr = 1'b1;
    step("clr_ok", 8'b00000000, All);
    fault_clr = 1'b0;
    repeat (3) step("clr_dead", 8'b00000000, All);
    step("clr_resume", 8'b10010001, All);

    rst = 1'b1;
    step("rst_mid", 8'b00000000, All);
    rst = 1'b0;
    repeat (3) step("rst_mid_dead", 8'b00000000, All);
    step("rst_mid_resume", 8'b10010001, All);

    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      pwm       = ($urandom_range(0, 3) != 0);
      m3step    = 4'($urandom_range(0, 8));
      aE        = 1'($urandom_range(0, 1));
      aH1_L0    = 1'($urandom_range(0, 1));
      bE        = 1'($urandom_range(0, 1));
      bH1_L0    = 1'($urandom_range(0, 1));
      cE        = 1'($urandom_range(0, 1));
      cH1_L0    = 1'($urandom_range(0, 1));
      ocp       = ($urandom_range(0, 39) == 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      step("random", 8'b00000000, 8'b00000000);
    end

    rst = 1'b1; ocp = 1'b0; fault_clr = 1'b0;
    repeat (2) step("final_reset", 8'b00000000, All);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
